float_adder_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `float_adder` instance (E=8, M=23, 32-bit) between `N` requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester per cycle and drives the shared adder. It registers the sum together with the requester ID onto a single valid/ready result port. It sits between the vector lanes that issue float additions and the write-back logic that consumes their results.

---
 rtl/float_pkg.sv | 18 +
 rtl/float_adder_arb_if.sv | 25 ++
 rtl/float_adder.sv | 92 +++++++++
 rtl/float_adder_arb_rr_arbiter.sv | 43 ++++
 rtl/float_adder_arb.sv | 109 ++++++++++
 tb/tb_float_adder_arb.sv | 285 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared single-precision constants, operand-pair type and ID width helper
package float_pkg;

    localparam int FP_E     = 8;
    localparam int FP_M     = 23;
    localparam int FP_WIDTH = 1 + FP_E + FP_M;

    typedef struct packed {
        logic [FP_WIDTH-1:0] a;
        logic [FP_WIDTH-1:0] b;
    } operand_pair_t;

    // A single requester still needs a 1-bit ID field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/float_adder_arb_if.sv
// rtl/float_adder_arb_if.sv - requester and result handshake bundle for float_adder_arb
interface float_adder_arb_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = float_pkg::id_width(N)
);
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*WIDTH-1:0] req_a;
    logic [N*WIDTH-1:0] req_b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [IDW-1:0]     out_id;

    modport master (
        output req_valid, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_a, req_b, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/float_adder.sv
// rtl/float_adder.sv - combinational single-precision adder, round-to-nearest-even
module float_adder
    import float_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    localparam int E  = FP_E;
    localparam int M  = FP_M;
    localparam int MW = M + 4;
    localparam int EW = E + 2;

    logic          sa, sb, sx, sy, swap, eff_sub, found, rnd;
    logic [E-1:0]  ea, eb, ex, ey, ex_eff, ey_eff, d;
    logic [M-1:0]  fa, fb, fx, fy;
    logic [MW-1:0] mx, my, mask, aligned, norm;
    logic [MW:0]   raw;
    logic [EW-1:0] e, lz, sh, exp_f;
    logic [E+M-1:0] base, mag;

    always_comb begin
        sa = a[WIDTH-1];  ea = a[WIDTH-2 -: E];  fa = a[M-1:0];
        sb = b[WIDTH-1];  eb = b[WIDTH-2 -: E];  fb = b[M-1:0];
        swap = {eb, fb} > {ea, fa};
        sx = swap ? sb : sa;  ex = swap ? eb : ea;  fx = swap ? fb : fa;
        sy = swap ? sa : sb;  ey = swap ? ea : eb;  fy = swap ? fa : fb;
        mx = {(ex != '0), fx, 3'b000};
        my = {(ey != '0), fy, 3'b000};
        ex_eff = (ex == '0) ? E'(1) : ex;
        ey_eff = (ey == '0) ? E'(1) : ey;
        d = ex_eff - ey_eff;
        mask = '0;
        aligned = '0;
        lz = '0;
        sh = '0;
        found = 1'b0;

        // Guard/round/sticky alignment; everything shifted past the sticky bit ORs into it.
        if (d >= E'(MW)) begin
            aligned = {{(MW-1){1'b0}}, |my};
        end else begin
            mask = (MW'(1) << d) - MW'(1);
            aligned = (my >> d) | {{(MW-1){1'b0}}, |(my & mask)};
        end

        eff_sub = sx ^ sy;
        raw = eff_sub ? ({1'b0, mx} - {1'b0, aligned}) : ({1'b0, mx} + {1'b0, aligned});
        e = {2'b00, ex_eff};

        if (raw[MW]) begin
            norm = raw[MW:1] | {{(MW-1){1'b0}}, raw[0]};
            e = e + EW'(1);
        end else begin
            norm = raw[MW-1:0];
            for (int i = MW - 1; i >= 0; i--) begin
                if (!found) begin
                    if (norm[i]) found = 1'b1;
                    else lz = lz + EW'(1);
                end
            end
            // Never normalise below the minimum exponent: the result becomes subnormal.
            sh = (lz >= e) ? (e - EW'(1)) : lz;
            norm = norm << sh;
            e = e - sh;
        end

        exp_f = norm[MW-1] ? e : '0;
        base = {exp_f[E-1:0], norm[MW-2:3]};
        rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
        mag = base + {{(E+M-1){1'b0}}, rnd};
        sum = {sx, mag};

        if (raw == '0) begin
            sum = {sx & sy, {(WIDTH-1){1'b0}}};
        end else if (norm[MW-1] && (e >= EW'((1 << E) - 1))) begin
            sum = {sx, {E{1'b1}}, {M{1'b0}}};
        end

        if ((ea == {E{1'b1}} && fa != '0) || (eb == {E{1'b1}} && fb != '0) ||
            (ea == {E{1'b1}} && eb == {E{1'b1}} && sa != sb)) begin
            sum = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
        end else if (ea == {E{1'b1}}) begin
            sum = a;
        end else if (eb == {E{1'b1}}) begin
            sum = b;
        end
    end

endmodule

// File: rtl/float_adder_arb_rr_arbiter.sv
// rtl/float_adder_arb_rr_arbiter.sv - round-robin arbiter with pointer advance strobe
module rr_arbiter
    import float_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           grant_any
);
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cur;

    // Walk ptr, ptr+1, ... modulo N; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cur       = ptr;
        for (int i = 0; i < N; i++) begin
            if (!grant_any && req[cur]) begin
                grant[cur] = 1'b1;
                grant_idx  = cur;
                grant_any  = 1'b1;
            end
            cur = (cur == IDW'(N - 1)) ? '0 : cur + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_any) begin
            ptr <= (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

endmodule

// File: rtl/float_adder_arb.sv
// rtl/float_adder_arb.sv - N-way round-robin front end sharing one float_adder; FLOAT_ADDER_ARB_PIPE_EN adds an operand stage
module float_adder_arb
    import float_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = id_width(N)
) (
    input logic              clk,
    input logic              rst,
    float_adder_arb_if.slave bus
);
    logic [N-1:0]     grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             stage_free;
    logic             issue_ok;
    logic             in_fire;
    logic             load_out;
    operand_pair_t    sel_ops;
    operand_pair_t    add_ops;
    logic [IDW-1:0]   add_id;
    logic [WIDTH-1:0] add_sum;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [IDW-1:0]   out_id_q;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .advance   (in_fire),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_ops = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_ops.a = bus.req_a[i*WIDTH +: WIDTH];
                sel_ops.b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef FLOAT_ADDER_ARB_PIPE_EN
    logic           s1_valid;
    operand_pair_t  s1_ops;
    logic [IDW-1:0] s1_id;
    logic           out_free;

    assign out_free   = !out_valid_q || bus.out_ready;
    assign stage_free = !s1_valid || out_free;
    assign load_out   = s1_valid && out_free;
    assign add_ops    = s1_ops;
    assign add_id     = s1_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ops   <= '0;
            s1_id    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_ops   <= sel_ops;
            s1_id    <= grant_idx;
        end else if (load_out) begin
            s1_valid <= 1'b0;
        end
    end
`else
    assign stage_free = !out_valid_q || bus.out_ready;
    assign load_out   = in_fire;
    assign add_ops    = sel_ops;
    assign add_id     = grant_idx;
`endif

    // Reset is asynchronous, so ready must drop with rst rather than at the next edge.
    assign issue_ok      = stage_free && !rst;
    assign in_fire       = grant_any && issue_ok;
    assign bus.req_ready = issue_ok ? grant : '0;

    float_adder #(.WIDTH(WIDTH)) u_add (
        .a   (add_ops.a),
        .b   (add_ops.b),
        .sum (add_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_data_q  <= add_sum;
            out_id_q    <= add_id;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_float_adder_arb.sv
// tb/tb_float_adder_arb.sv - directed self-checking bench for float_adder_arb
module tb_float_adder_arb;
    import float_pkg::*;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;
`ifdef FLOAT_ADDER_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] FM3 = 32'hC0400000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_adder_arb_if #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    float_adder_arb #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] ref_a, ref_b, ref_sum;
    float_adder #(.WIDTH(32)) u_ref (.a(ref_a), .b(ref_b), .sum(ref_sum));

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", bus.out_data); end
        checks++;
        if (bus.out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id: got %0d want 0", bus.out_id); end
        checks++;
        if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        bus.req_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        set_ops(0, F1, F2);
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
        step();
        bus.req_valid = '0;
        repeat (LAT - 1) step();
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        checks++;
        if (bus.out_data !== F3) begin errors++; $display("FAIL single_data: got %h want %h", bus.out_data, F3); end
        checks++;
        if (bus.out_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", bus.out_id); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        logic [1:0] exp_id;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ops(i, F1, F2);
        bus.req_valid = '1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 6 + LAT; c++) begin
            @(negedge clk);
            if (c < 6) begin
                exp_rdy = 4'b0001 << (c % 4);
                checks++;
                if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", c, bus.req_ready, exp_rdy); end
            end
            if (c >= LAT) begin
                exp_id = 2'((c - LAT) % 4);
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id || bus.out_data !== F3) begin
                    errors++;
                    $display("FAIL fair_out[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h", c, bus.out_valid, bus.out_id, bus.out_data, exp_id, F3);
                end
            end
            step();
            if (c == 5) bus.req_valid = '0;
        end
        step();
    endtask

    task automatic test_wrap_skip();
        do_reset();
        bus.out_ready = 1'b1;
        set_ops(1, F1, F1);
        set_ops(2, F1, F1);
        set_ops(3, F2, F2);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_setup: got %b want 0100", bus.req_ready); end
        step();
        bus.req_valid = 4'b1010;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3: got %b want 1000", bus.req_ready); end
        step();
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant1: got %b want 0010", bus.req_ready); end
        step();
        bus.req_valid = '0;
        repeat (LAT + 1) step();
    endtask

    task automatic test_backpressure();
        int k;
        do_reset();
        bus.out_ready = 1'b0;
        set_ops(2, F1, F1);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_ready: got %b want 0100", bus.req_ready); end
        step();
        bus.req_valid = '0;
        repeat (LAT - 1) step();
        set_ops(2, F2, F2);
        bus.req_valid = 4'b0100;
`ifdef FLOAT_ADDER_ARB_PIPE_EN
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_s1_fill: got %b want 0100", bus.req_ready); end
        step();
`endif
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b1 || bus.out_data !== F2 || bus.out_id !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h id=%0d want rdy=0000 v=1 d=%h id=2", c, bus.req_ready, bus.out_valid, bus.out_data, bus.out_id, F2);
            end
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b want 0100", bus.req_ready); end
        step();
        bus.req_valid = '0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== F4 || bus.out_id !== 2'd2) begin
            errors++;
            $display("FAIL bp_release_out: got v=%b d=%h id=%0d want v=1 d=%h id=2", bus.out_valid, bus.out_data, bus.out_id, F4);
        end
        k = 0;
        while (bus.out_valid === 1'b1 && k < 8) begin
            step();
            k++;
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_timeout: got v=%b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0;
        set_ops(1, F1, F2);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_setup: got %b want 0010", bus.req_ready); end
        step();
        bus.req_valid = '0;
        repeat (LAT - 1) step();
        set_ops(0, F1, F1);
        set_ops(2, F2, F2);
        bus.req_valid = 4'b0101;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000 || bus.out_data !== 32'h0 || bus.out_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_async_clear: got v=%b rdy=%b d=%h id=%0d want v=0 rdy=0000 d=0 id=0", bus.out_valid, bus.req_ready, bus.out_data, bus.out_id);
        end
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_winner: got %b want 0001", bus.req_ready); end
        step();
        bus.req_valid = '0;
        repeat (LAT - 1) step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== F2) begin
            errors++;
            $display("FAIL mid_first_result: got v=%b id=%0d d=%h want v=1 id=0 d=%h", bus.out_valid, bus.out_id, bus.out_data, F2);
        end
        repeat (LAT + 1) step();
    endtask

    task automatic test_cancellation();
        ref_a = F3;
        ref_b = FM3;
        set_ops(0, F3, FM3);
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL cancel_ready: got %b want 0001", bus.req_ready); end
        step();
        bus.req_valid = '0;
        repeat (LAT - 1) step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0) begin errors++; $display("FAIL cancel_valid: got v=%b id=%0d want v=1 id=0", bus.out_valid, bus.out_id); end
        checks++;
        if (bus.out_data !== ref_sum) begin errors++; $display("FAIL cancel_ref: got %h want %h", bus.out_data, ref_sum); end
        checks++;
        if (bus.out_data !== 32'h00000000) begin errors++; $display("FAIL cancel_zero: got %h want 00000000", bus.out_data); end
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.out_ready = 1'b0;
        ref_a = '0;
        ref_b = '0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap_skip();
        test_backpressure();
        test_reset_mid();
        test_cancellation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
